mem_responder: RTL and testbench

- Memory-side responder for the CPU data-memory request interface.
- Accepts single read/write requests (start_read / w, 15-bit word address, 32-bit write data) from the CPU-side router.
- Services each request from internal word storage after a programmable number of wait states, then returns a one-cycle readrdy or saverdy pulse with read data.
- Sits between the RAM-select outputs of the memory router and the CPU memory controller's readrdy/saverdy inputs.

---
 rtl/mem_responder_if.sv | 33 +++
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bundle between the CPU-side router and mem_responder
//
// Signals:
//   start_read  read request strobe          (master -> slave)
//   w           write request strobe         (master -> slave)
//   addr[14:0]  word address                 (master -> slave)
//   wdata[31:0] write data                   (master -> slave)
//   rdata[31:0] read data                    (slave -> master)
//   readrdy     one-cycle read-complete      (slave -> master)
//   saverdy     one-cycle write-complete     (slave -> master)
//   busy        request in flight            (slave -> master)
//   oor         out-of-range flag pulse      (slave -> master)
interface mem_responder_if;
  logic        start_read;
  logic        w;
  logic [14:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        readrdy;
  logic        saverdy;
  logic        busy;
  logic        oor;

  modport master (
    output start_read, w, addr, wdata,
    input  rdata, readrdy, saverdy, busy, oor
  );

  modport slave (
    input  start_read, w, addr, wdata,
    output rdata, readrdy, saverdy, busy, oor
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder servicing single read/write requests after WAIT wait states
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  mem_responder_if.slave: start_read/w/addr/wdata in, rdata/readrdy/saverdy/busy/oor out
//
// Parameters: AW (word address width), DEPTH (= 2**AW words), WAIT (0..15 wait states).
// Optional feature macro: MEM_RESPONDER_OOR_EN
//   defined   - addresses >= DEPTH suppress the write, read back 0, and pulse oor with the rdy
//   undefined - upper address bits are ignored (aliasing modulo DEPTH), oor tied to 0
module mem_responder #(
  parameter int AW    = 12,
  parameter int DEPTH = 4096,
  parameter int WAIT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        op_wr;
  logic [14:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] rdata_q;
  logic        readrdy_q;
  logic        saverdy_q;
  logic        busy_q;
  logic        oor_q;

  // Storage is deliberately not reset so it maps onto plain RAM.
  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          oor_hit;

  assign idx = cap_addr[AW-1:0];

`ifdef MEM_RESPONDER_OOR_EN
  assign oor_hit = (32'(cap_addr) >= 32'(DEPTH));
`else
  assign oor_hit = 1'b0;
  // Upper address bits are intentionally dropped: the address aliases modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cap_addr[14:AW];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      op_wr     <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
      readrdy_q <= 1'b0;
      saverdy_q <= 1'b0;
      busy_q    <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.w || bus.start_read) begin
            // Write wins when both strobes are high.
            op_wr     <= bus.w;
            cap_addr  <= bus.addr;
            cap_wdata <= bus.wdata;
            busy_q    <= 1'b1;
            if (WAIT == 0) begin
              state <= S_ACCESS;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= 4'(WAIT);
            end
          end
        end
        S_WAIT: begin
          // Counter reaches 0 on the same edge that leaves WAIT, so WAIT lasts exactly WAIT cycles.
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!op_wr) begin
            rdata_q <= oor_hit ? 32'd0 : mem[idx];
          end
          readrdy_q <= !op_wr;
          saverdy_q <= op_wr;
          oor_q     <= oor_hit;
          state     <= S_RESP;
        end
        S_RESP: begin
          readrdy_q <= 1'b0;
          saverdy_q <= 1'b0;
          oor_q     <= 1'b0;
          busy_q    <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Commit happens on the ACCESS->RESP edge; a reset beforehand forces IDLE so nothing is written.
  always_ff @(posedge clk) begin
    if (rst && state == S_ACCESS && op_wr && !oor_hit) begin
      mem[idx] <= cap_wdata;
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.readrdy = readrdy_q;
  assign bus.saverdy = saverdy_q;
  assign bus.busy    = busy_q;
  assign bus.oor     = oor_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - table-driven self-checking bench for mem_responder
module tb_mem_responder;

  localparam int W = 2;

`ifdef MEM_RESPONDER_OOR_EN
  localparam bit OOR = 1'b1;
`else
  localparam bit OOR = 1'b0;
`endif

  logic clk;
  logic rst;

  mem_responder_if bus ();

  mem_responder #(.AW(12), .DEPTH(4096), .WAIT(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] hold_val;
  logic        hold_known;

  // op: 0 = read, 1 = write, 2 = write and read together
  typedef struct {
    logic [1:0]  op;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_oor;
    logic        poke;
    string       name;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge right after the capture edge (j = 0); walks through j = W+3.
  task automatic run_cycles(input bit wr, input bit rd, input bit exp_oor, input bit chk_data,
                            input logic [31:0] exp_rd, input bit poke, input string name);
    logic [3:0] exp_v;
    for (int j = 0; j <= W + 3; j++) begin
      if (j > 0) @(negedge clk);
      exp_v = {1'(j <= W + 1), 1'(rd && j == W + 1), 1'(wr && j == W + 1), 1'(exp_oor && j == W + 1)};
      chk($sformatf("%s busy/readrdy/saverdy/oor j=%0d", name, j),
          {28'd0, bus.busy, bus.readrdy, bus.saverdy, bus.oor}, {28'd0, exp_v});
      if (chk_data && j == W + 1) chk({name, " rdata"}, bus.rdata, exp_rd);
      if (j == W + 3) begin
        if (rd && chk_data) chk({name, " rdata hold"}, bus.rdata, exp_rd);
        else if (!rd && hold_known) chk({name, " rdata untouched"}, bus.rdata, hold_val);
      end
      // Request strobe while busy must be ignored.
      if (poke && j == 1) begin
        bus.start_read = 1'b1;
        bus.addr       = 15'h020;
      end else begin
        bus.start_read = 1'b0;
      end
    end
    if (rd && chk_data) begin
      hold_val   = exp_rd;
      hold_known = 1'b1;
    end
  endtask

  // Must be entered at a negedge.
  task automatic do_req(input vec_t v);
    bus.w          = (v.op != 2'd0);
    bus.start_read = (v.op != 2'd1);
    bus.addr       = v.addr;
    bus.wdata      = v.wdata;
    @(posedge clk);
    @(negedge clk);
    bus.w          = 1'b0;
    bus.start_read = 1'b0;
    bus.wdata      = 32'h0;
    run_cycles(v.op != 2'd0, v.op == 2'd0, v.exp_oor, v.op == 2'd0, v.exp_rdata, v.poke, v.name);
  endtask

  initial begin
    vecs[0]  = '{2'd1, 15'h0005, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, "wr_005"};
    vecs[1]  = '{2'd0, 15'h0005, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, "rd_005"};
    vecs[2]  = '{2'd2, 15'h0010, 32'h12345678, 32'h0,        1'b0, 1'b0, "both_010"};
    vecs[3]  = '{2'd0, 15'h0010, 32'h0,        32'h12345678, 1'b0, 1'b0, "rd_010"};
    vecs[4]  = '{2'd0, 15'h0005, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, "rd_005_poke"};
    vecs[5]  = '{2'd1, 15'h0030, 32'h11111111, 32'h0,        1'b0, 1'b0, "wr_030"};
    vecs[6]  = '{2'd1, 15'h1005, 32'hCAFEF00D, 32'h0,        OOR,  1'b0, "wr_1005"};
    vecs[7]  = '{2'd0, 15'h0005, 32'h0,        OOR ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0, 1'b0, "rd_005_after"};
    vecs[8]  = '{2'd0, 15'h1005, 32'h0,        OOR ? 32'h0 : 32'hCAFEF00D, OOR, 1'b0, "rd_1005"};
    vecs[9]  = '{2'd1, 15'h0FFF, 32'h0BADF00D, 32'h0,        1'b0, 1'b0, "wr_fff"};
    vecs[10] = '{2'd0, 15'h0FFF, 32'h0,        32'h0BADF00D, 1'b0, 1'b1, "rd_fff_poke"};

    hold_val   = 32'h0;
    hold_known = 1'b1;

    // Reset held with a pending read: everything stays idle.
    rst            = 1'b0;
    bus.start_read = 1'b1;
    bus.w          = 1'b0;
    bus.addr       = 15'h0005;
    bus.wdata      = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset flags %0d", i),
          {28'd0, bus.busy, bus.readrdy, bus.saverdy, bus.oor}, 32'd0);
      chk($sformatf("reset rdata %0d", i), bus.rdata, 32'd0);
    end
    // Release: the still-asserted read is captured at the first edge.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_read = 1'b0;
    run_cycles(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "post_reset_rd");
    hold_known = 1'b0;

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      do_req(vecs[i]);
      @(negedge clk);
    end

    // Reset during WAIT of a write to 0x030: abandoned, old contents survive.
    bus.w     = 1'b1;
    bus.addr  = 15'h0030;
    bus.wdata = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    bus.w = 1'b0;
    chk("midrst busy before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst busy async", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("midrst flags %0d", i),
          {28'd0, bus.busy, bus.readrdy, bus.saverdy, bus.oor}, 32'd0);
    end
    chk("midrst rdata", bus.rdata, 32'd0);
    rst        = 1'b1;
    hold_val   = 32'h0;
    hold_known = 1'b1;
    @(negedge clk);
    do_req('{2'd0, 15'h0030, 32'h0, 32'h11111111, 1'b0, 1'b0, "rd_030_after_rst"});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
